// File: rtl/pseq_pkg.sv
// Shared types and widths for the frame-synchronous pattern sequencer.
// Used by pattern_seq_ctrl and key_debounce.
package pseq_pkg;

  localparam int PSEL_W = 2;
  localparam int FCNT_W = 8;
  localparam int DEB_W  = 20;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pseq_state_e;

  // Next pattern index, wrapping to 0 after the last selectable pattern.
  function automatic logic [PSEL_W-1:0] next_psel(input logic [PSEL_W-1:0] cur,
                                                  input logic [2:0]        num_pat);
    logic [2:0] last;
    last = num_pat - 3'd1;
    if ({1'b0, cur} >= last) begin
      return '0;
    end
    return cur + PSEL_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Front-panel key conditioner: 2-flop synchronizer, stability counter and
// debounced level. Emits a one-cycle press pulse on each accepted 1->0
// transition of the debounced level; releases produce nothing.
module key_debounce
  import pseq_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd50000
) (
  input  logic px_clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_CYCLES - DEB_W'(1);

  logic             key_s1;
  logic             key_s2;
  logic             key_db;
  logic [DEB_W-1:0] deb_cnt;
  logic             differs;
  logic             flip;

  assign differs = (key_s2 != key_db);
  assign flip    = differs && (deb_cnt == DEB_LAST);

  // Bring the asynchronous key into px_clk; idle level is released (1).
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Count consecutive samples that disagree with the debounced level.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      deb_cnt <= '0;
      key_db  <= 1'b1;
    end else if (!differs) begin
      deb_cnt <= '0;
    end else if (flip) begin
      deb_cnt <= '0;
      key_db  <= ~key_db;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Registered press pulse: only the 1->0 flip of the debounced level counts.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      press <= 1'b0;
    end else begin
      press <= flip & key_db;
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Frame-synchronous pattern-select sequencer for the test pattern generator.
// Key presses (debounced) request a pattern advance that is applied on the
// next vsync rising edge, so a frame is never torn.
// Build option: define PSEQ_AUTO_EN to add automatic advance every
// FRAMES_PER_PAT frames, gated by auto_en. Without it auto_en is unused.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no manual request outstanding; auto advance may fire
//   PEND  | a press was accepted, advance on the next vsync rise
module pattern_seq_ctrl
  import pseq_pkg::*;
#(
  parameter logic [DEB_W-1:0]  DEB_CYCLES     = 20'd50000,
  parameter logic [FCNT_W-1:0] FRAMES_PER_PAT = 8'd60,
  parameter logic [2:0]        NUM_PAT        = 3'd4
) (
  input  logic              px_clk,
  input  logic              rstn,
  input  logic              vsync,
  input  logic              key_n,
  input  logic              auto_en,
  output logic [PSEL_W-1:0] psel,
  output logic              pat_chg,
  output logic              pend,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FRAMES_PER_PAT - FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = '1;

  pseq_state_e state_q;
  pseq_state_e state_d;
  logic        press;
  logic        vsync_d;
  logic        vs_rise;
  logic        auto_hit;
  logic        advance;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .px_clk(px_clk),
    .rstn  (rstn),
    .key_n (key_n),
    .press (press)
  );

  // Registered frame-start strobe, one cycle after vsync is first seen high.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      vsync_d <= vsync;
      vs_rise <= vsync & ~vsync_d;
    end
  end

`ifdef PSEQ_AUTO_EN
  assign auto_hit = auto_en & vs_rise & (frame_cnt == FCNT_LAST);
`else
  logic unused_auto;
  assign unused_auto = auto_en ^ (|FCNT_LAST);
  assign auto_hit    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the single advance strobe; auto only fires from IDLE,
  // so a manual and an auto request can never advance twice in one frame.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (auto_hit) begin
          advance = 1'b1;
        end
        if (press) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (vs_rise) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pend = (state_q == PEND);

  // Pattern select and change strobe, both updated on the advance edge.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      psel    <= '0;
      pat_chg <= 1'b0;
    end else begin
      pat_chg <= advance;
      if (advance) begin
        psel <= next_psel(psel, NUM_PAT);
      end
    end
  end

  // Frames shown since the last change, saturating at the counter maximum.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
    end else if (advance) begin
      frame_cnt <= '0;
    end else if (vs_rise && (frame_cnt != FCNT_MAX)) begin
      frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl: directed scenarios plus random
// key/vsync traffic, compared every cycle against a frame-level model.
module tb_pattern_seq_ctrl;
  import pseq_pkg::*;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [7:0]  FPP = 8'd3;
  localparam logic [2:0]  NP  = 3'd4;
`ifdef PSEQ_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       px_clk;
  logic       rstn;
  logic       vsync;
  logic       key_n;
  logic       auto_en;
  logic [1:0] psel;
  logic       pat_chg;
  logic       pend;
  logic [7:0] frame_cnt;

  pattern_seq_ctrl #(
    .DEB_CYCLES    (DEB),
    .FRAMES_PER_PAT(FPP),
    .NUM_PAT       (NP)
  ) dut (
    .px_clk   (px_clk),
    .rstn     (rstn),
    .vsync    (vsync),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .psel     (psel),
    .pat_chg  (pat_chg),
    .pend     (pend),
    .frame_cnt(frame_cnt)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  int n_vec = 0;
  int n_err = 0;
  int chg_seen = 0;

  // reference model state
  int m_psel, m_fcnt;
  bit m_pend, m_chg, m_db, m_press, m_vprev, m_vr;
  bit sync_pipe[$];
  bit samp_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_psel = 0; m_fcnt = 0; m_pend = 0; m_chg = 0;
    m_db = 1; m_press = 0; m_vprev = 0; m_vr = 0;
    sync_pipe = {1'b1, 1'b1};
    samp_hist.delete();
  endtask

  // One clock edge of behaviour, from the input values held across the edge.
  task automatic model_edge();
    bit adv, all_diff, s;
    adv = (m_pend && m_vr) ||
          (AUTO && !m_pend && auto_en && m_vr && (m_fcnt == int'(FPP) - 1));
    m_pend = m_pend ? !m_vr : m_press;
    m_chg  = adv;
    if (adv) begin
      m_psel = (m_psel + 1) % int'(NP);
      m_fcnt = 0;
    end else if (m_vr && m_fcnt < 255) begin
      m_fcnt++;
    end
    // key: accept a new level once DEB consecutive samples disagree with it
    s = sync_pipe[0];
    sync_pipe = {sync_pipe[1], key_n};
    samp_hist.push_back(s);
    if (samp_hist.size() > int'(DEB)) void'(samp_hist.pop_front());
    all_diff = (samp_hist.size() == int'(DEB));
    foreach (samp_hist[i]) if (samp_hist[i] == m_db) all_diff = 0;
    m_press = all_diff && m_db;
    if (all_diff) begin
      m_db = !m_db;
      samp_hist.delete();
    end
    m_vr = vsync && !m_vprev;
    m_vprev = vsync;
  endtask

  task automatic compare_all();
    check("psel", 32'(psel), 32'(m_psel));
    check("pat_chg", 32'(pat_chg), 32'(m_chg));
    check("pend", 32'(pend), 32'(m_pend));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
  endtask

  task automatic step();
    @(posedge px_clk);
    model_edge();
    #1;
    if (pat_chg === 1'b1) chg_seen++;
    compare_all();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #2;
    check("rst_psel", 32'(psel), 0);
    check("rst_pat_chg", 32'(pat_chg), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    model_reset();
    @(posedge px_clk);
    #1;
    compare_all();
    rstn = 1'b1;
  endtask

  task automatic frame(input int len);
    vsync = 1'b1;
    step(); step();
    vsync = 1'b0;
    for (int i = 2; i < len; i++) step();
  endtask

  task automatic press_key();
    key_n = 1'b0;
    repeat (8) step();
    key_n = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int lat, p0, vs_left, vs_len, vs_hi, key_left;
    rstn = 1'b1; vsync = 1'b0; key_n = 1'b1; auto_en = 1'b0;
    model_reset();
    #12;
    // 1: reset
    apply_reset();
    repeat (3) step();

    // 2: clean press, pend latency, then advance on the frame
    lat = 0;
    key_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pend === 1'b1 && lat == 0) lat = i;
    end
    key_n = 1'b1;
    check("deb_latency", 32'(lat), 7);
    chg_seen = 0;
    frame(12);
    check("adv_psel", 32'(psel), 1);
    check("adv_pend", 32'(pend), 0);
    check("adv_pulses", 32'(chg_seen), 1);

    // 3: short glitches are ignored
    repeat (5) begin
      key_n = 1'b0; repeat (3) step();
      key_n = 1'b1; repeat (3) step();
    end
    check("glitch_pend", 32'(pend), 0);
    check("glitch_psel", 32'(psel), 1);

    // 4: auto cycling over 12 frames
    apply_reset();
    auto_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      frame(6);
      check("auto_psel", 32'(psel), AUTO ? 32'((k / 3) % 4) : 0);
      check("auto_fcnt", 32'(frame_cnt), AUTO ? 32'(k % 3) : 32'(k));
    end
    auto_en = 1'b0;

    // 5: press accepted on the same cycle as vs_rise, then a second press
    apply_reset();
    key_n = 1'b0;
    repeat (5) step();
    vsync = 1'b1;
    step(); step();
    vsync = 1'b0;
    check("sim_pend", 32'(pend), 1);
    check("sim_psel", 32'(psel), 0);
    check("sim_fcnt", 32'(frame_cnt), 1);
    key_n = 1'b1; repeat (8) step();
    key_n = 1'b0; repeat (8) step();
    key_n = 1'b1;
    check("second_press_pend", 32'(pend), 1);
    frame(12);
    check("one_adv_psel", 32'(psel), 1);
    check("one_adv_pend", 32'(pend), 0);
    frame(12);
    check("no_queue_psel", 32'(psel), 1);

    // 6: reset while PEND with psel=2
    press_key();
    frame(10);
    press_key();
    check("pre_rst_psel", 32'(psel), 2);
    check("pre_rst_pend", 32'(pend), 1);
    apply_reset();
    chg_seen = 0;
    frame(10);
    check("post_rst_psel", 32'(psel), 0);
    check("post_rst_chg", 32'(chg_seen), 0);

    // random traffic
    apply_reset();
    vs_left = 0; vs_len = 1; vs_hi = 1; key_left = 0;
    p0 = 0;
    for (int c = 0; c < 4000; c++) begin
      if (vs_left == 0) begin
        vs_len = int'($urandom_range(25, 5));
        vs_hi  = int'($urandom_range(3, 1));
        vs_left = vs_len;
      end
      vsync = ((vs_len - vs_left) < vs_hi);
      vs_left--;
      if (key_left == 0) begin
        key_n = ~key_n;
        key_left = int'($urandom_range(14, 1));
      end
      key_left--;
      if ($urandom_range(63, 0) == 0) auto_en = ~auto_en;
      if ($urandom_range(1999, 0) == 0) apply_reset();
      else step();
      if (pat_chg === 1'b1) p0++;
    end
    check("rand_saw_changes", 32'(p0 > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
